// File: rtl/udcnt_pkg.sv
// rtl/udcnt_pkg.sv - shared types, one-hot state constants and load clamp for updown_cnt_ctl
//
// Contents:
//   state_t                one-hot state type (IDLE/CNTUP/CNTDN/FAULT)
//   IDLE, CNTUP, CNTDN, FAULT  state constants
//   clamp_val()            limits a value to [lo, hi]
package udcnt_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_CNTUP = 4'b0010,
      ST_CNTDN = 4'b0100,
      ST_FAULT = 4'b1000
   } state_t;

   localparam state_t IDLE  = ST_IDLE;
   localparam state_t CNTUP = ST_CNTUP;
   localparam state_t CNTDN = ST_CNTDN;
   localparam state_t FAULT = ST_FAULT;

   function automatic int unsigned clamp_val(input int unsigned v,
                                             input int unsigned lo,
                                             input int unsigned hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/updown_cnt_ctl_if.sv
// rtl/updown_cnt_ctl_if.sv - control/status bundle between a user and updown_cnt_ctl
//
// Signals:
//   act, up_dwn_n, clr, load, load_val   controls driven by the master
//   count, ovflw, unflw, state_o         registered status driven by the counter (slave)
interface updown_cnt_ctl_if #(
   parameter int COUNTER_WIDTH = 8
);
   logic                     act;
   logic                     up_dwn_n;
   logic                     clr;
   logic                     load;
   logic [COUNTER_WIDTH-1:0] load_val;
   logic [COUNTER_WIDTH-1:0] count;
   logic                     ovflw;
   logic                     unflw;
   logic [3:0]               state_o;

   modport master (
      output act, up_dwn_n, clr, load, load_val,
      input  count, ovflw, unflw, state_o
   );

   modport slave (
      input  act, up_dwn_n, clr, load, load_val,
      output count, ovflw, unflw, state_o
   );
endinterface

// File: rtl/udcnt_next.sv
// rtl/udcnt_next.sv - combinational next-state/next-count logic of updown_cnt_ctl
//
// Inputs:  state, count, act, up_dwn_n, clr, load, load_val
// Outputs: next_state, next_count, set_ovflw, set_unflw
// Build option: UDCNT_WRAP_EN selects wrap-around at the bounds instead of locking in FAULT.
module udcnt_next
   import udcnt_pkg::*;
#(
   parameter int COUNTER_WIDTH = 8,
   parameter int MIN_VAL       = 0,
   parameter int MAX_VAL       = (2**COUNTER_WIDTH) - 1
) (
   input  state_t                   state,
   input  logic [COUNTER_WIDTH-1:0] count,
   input  logic                     act,
   input  logic                     up_dwn_n,
   input  logic                     clr,
   input  logic                     load,
   input  logic [COUNTER_WIDTH-1:0] load_val,
   output state_t                   next_state,
   output logic [COUNTER_WIDTH-1:0] next_count,
   output logic                     set_ovflw,
   output logic                     set_unflw
);

   localparam logic [COUNTER_WIDTH-1:0] MIN_C = COUNTER_WIDTH'(MIN_VAL);
   localparam logic [COUNTER_WIDTH-1:0] MAX_C = COUNTER_WIDTH'(MAX_VAL);

   logic [COUNTER_WIDTH-1:0] clamped;

   assign clamped = COUNTER_WIDTH'(clamp_val(32'(load_val),
                                             int'(MIN_VAL),
                                             int'(MAX_VAL)));

   always_comb begin
      next_state = state;
      next_count = count;
      set_ovflw  = 1'b0;
      set_unflw  = 1'b0;

      if (clr) begin
         // clr is the only way out of FAULT; a simultaneous load still applies
         next_state = IDLE;
         if (load) next_count = clamped;
      end else if (state == FAULT) begin
         // locked: hold everything until clr
      end else if (load) begin
         next_state = IDLE;
         next_count = clamped;
      end else if (!act) begin
         next_state = IDLE;
      end else if (up_dwn_n) begin
         if (count == MAX_C) begin
            set_ovflw = 1'b1;
`ifdef UDCNT_WRAP_EN
            next_count = MIN_C;
            next_state = CNTUP;
`else
            next_state = FAULT;
`endif
         end else begin
            next_count = count + 1'b1;
            next_state = CNTUP;
         end
      end else begin
         if (count == MIN_C) begin
            set_unflw = 1'b1;
`ifdef UDCNT_WRAP_EN
            next_count = MAX_C;
            next_state = CNTDN;
`else
            next_state = FAULT;
`endif
         end else begin
            next_count = count - 1'b1;
            next_state = CNTDN;
         end
      end
   end

endmodule

// File: rtl/updown_cnt_ctl.sv
// rtl/updown_cnt_ctl.sv - bounded up/down counter with load, sticky over/underflow and FAULT lock
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   updown_cnt_ctl_if.slave: act, up_dwn_n, clr, load, load_val in;
//         count, ovflw, unflw, state_o (one-hot) out, all registered
// Build option: UDCNT_WRAP_EN enables wrap-around at the bounds (FAULT unreachable).
module updown_cnt_ctl
   import udcnt_pkg::*;
#(
   parameter int COUNTER_WIDTH = 8,
   parameter int MIN_VAL       = 0,
   parameter int MAX_VAL       = (2**COUNTER_WIDTH) - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   updown_cnt_ctl_if.slave         bus
);

   generate
      if (COUNTER_WIDTH < 2 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
          MAX_VAL > (2**COUNTER_WIDTH) - 1) begin : g_bad_params
         $error("updown_cnt_ctl: need COUNTER_WIDTH>=2 and 0<=MIN_VAL<MAX_VAL<=2**COUNTER_WIDTH-1");
      end
   endgenerate

   localparam logic [COUNTER_WIDTH-1:0] MIN_C = COUNTER_WIDTH'(MIN_VAL);

   state_t                   state_q;
   state_t                   state_d;
   logic [COUNTER_WIDTH-1:0] count_q;
   logic [COUNTER_WIDTH-1:0] count_d;
   logic                     ovflw_q;
   logic                     unflw_q;
   logic                     set_ovflw;
   logic                     set_unflw;

   udcnt_next #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .MIN_VAL       (MIN_VAL),
      .MAX_VAL       (MAX_VAL)
   ) u_next (
      .state      (state_q),
      .count      (count_q),
      .act        (bus.act),
      .up_dwn_n   (bus.up_dwn_n),
      .clr        (bus.clr),
      .load       (bus.load),
      .load_val   (bus.load_val),
      .next_state (state_d),
      .next_count (count_d),
      .set_ovflw  (set_ovflw),
      .set_unflw  (set_unflw)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= MIN_C;
         ovflw_q <= 1'b0;
         unflw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         // flags are sticky; clr wins over a same-cycle set
         ovflw_q <= !bus.clr && (ovflw_q || set_ovflw);
         unflw_q <= !bus.clr && (unflw_q || set_unflw);
      end
   end

   assign bus.count   = count_q;
   assign bus.ovflw   = ovflw_q;
   assign bus.unflw   = unflw_q;
   assign bus.state_o = state_q;

endmodule

// File: tb/tb_updown_cnt_ctl.sv
// tb/tb_updown_cnt_ctl.sv - self-checking bench for updown_cnt_ctl (W=4, MIN=2, MAX=13)
module tb_updown_cnt_ctl;

   localparam int W    = 4;
   localparam int MINV = 2;
   localparam int MAXV = 13;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   updown_cnt_ctl_if #(.COUNTER_WIDTH(W)) bus ();

   updown_cnt_ctl #(
      .COUNTER_WIDTH (W),
      .MIN_VAL       (MINV),
      .MAX_VAL       (MAXV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: mode 0=idle 1=up 2=down 3=fault; state_o = 1 << mode
   int m_cnt   = MINV;
   int m_mode  = 0;
   bit m_ov    = 0;
   bit m_un    = 0;
   bit m_valid = 0;

   function automatic int clampm(input int v);
      return (v < MINV) ? MINV : (v > MAXV) ? MAXV : v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cnt = MINV; m_mode = 0; m_ov = 0; m_un = 0; m_valid = 1;
      end else if (bus.clr) begin
         m_ov = 0; m_un = 0; m_mode = 0;
         if (bus.load) m_cnt = clampm(int'(bus.load_val));
      end else if (m_mode == 3) begin
         m_mode = 3;
      end else if (bus.load) begin
         m_cnt = clampm(int'(bus.load_val)); m_mode = 0;
      end else if (!bus.act) begin
         m_mode = 0;
      end else if (bus.up_dwn_n) begin
         if (m_cnt == MAXV) begin
            m_ov = 1;
`ifdef UDCNT_WRAP_EN
            m_cnt = MINV; m_mode = 1;
`else
            m_mode = 3;
`endif
         end else begin
            m_cnt = m_cnt + 1; m_mode = 1;
         end
      end else begin
         if (m_cnt == MINV) begin
            m_un = 1;
`ifdef UDCNT_WRAP_EN
            m_cnt = MAXV; m_mode = 2;
`else
            m_mode = 3;
`endif
         end else begin
            m_cnt = m_cnt - 1; m_mode = 2;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_count", int'(bus.count), m_cnt);
         chk("model_state", int'(bus.state_o), 1 << m_mode);
         chk("model_ovflw", int'(bus.ovflw), int'(m_ov));
         chk("model_unflw", int'(bus.unflw), int'(m_un));
      end
   end

   task automatic cyc(input bit a, input bit ud, input bit c, input bit l, input int lv);
      bus.act = a; bus.up_dwn_n = ud; bus.clr = c; bus.load = l; bus.load_val = W'(lv);
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int cnt, input int st, input int ov, input int un);
      chk({name, "_count"}, int'(bus.count), cnt);
      chk({name, "_state"}, int'(bus.state_o), st);
      chk({name, "_ovflw"}, int'(bus.ovflw), ov);
      chk({name, "_unflw"}, int'(bus.unflw), un);
   endtask

   initial begin
      bus.act = 0; bus.up_dwn_n = 0; bus.clr = 0; bus.load = 0; bus.load_val = '0;
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      lit("reset", 2, 4'b0001, 0, 0);
      rst = 0;

      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      lit("up3", 5, 4'b0010, 0, 0);

      cyc(0, 0, 0, 1, 12);
      lit("load12", 12, 4'b0001, 0, 0);
      cyc(1, 1, 0, 0, 0);
      lit("up13", 13, 4'b0010, 0, 0);
      cyc(1, 1, 0, 0, 0);
      lit("ovf_fault", 13, 4'b1000, 1, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 5);
      cyc(1, 1, 0, 1, 9);
      lit("fault_hold", 13, 4'b1000, 1, 0);
      cyc(0, 0, 1, 0, 0);
      lit("clr_ovf", 13, 4'b0001, 0, 0);

      cyc(0, 0, 0, 1, 15);
      lit("clamp_hi", 13, 4'b0001, 0, 0);
      cyc(1, 1, 0, 1, 0);
      lit("clamp_lo", 2, 4'b0001, 0, 0);

      cyc(0, 0, 0, 1, 3);
      cyc(1, 0, 0, 0, 0);
      lit("down2", 2, 4'b0100, 0, 0);
      cyc(1, 0, 0, 0, 0);
      lit("unf_fault", 2, 4'b1000, 0, 1);
      cyc(1, 1, 1, 1, 7);
      lit("clr_load", 7, 4'b0001, 0, 0);

      cyc(1, 1, 0, 0, 0);
      lit("tog1", 8, 4'b0010, 0, 0);
      cyc(1, 0, 0, 0, 0);
      lit("tog2", 7, 4'b0100, 0, 0);
      cyc(1, 1, 0, 0, 0);
      lit("tog3", 8, 4'b0010, 0, 0);
      cyc(1, 0, 0, 0, 0);
      lit("tog4", 7, 4'b0100, 0, 0);

      cyc(0, 0, 0, 0, 0);
      lit("idle", 7, 4'b0001, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      lit("up9", 9, 4'b0010, 0, 0);
      rst = 1;
      cyc(1, 1, 0, 1, 11);
      lit("mid_rst", 2, 4'b0001, 0, 0);
      rst = 0;

`ifdef UDCNT_WRAP_EN
      cyc(0, 0, 0, 1, 13);
      cyc(1, 1, 0, 0, 0);
      lit("wrap_up", 2, 4'b0010, 1, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      lit("wrap_cont", 4, 4'b0010, 1, 0);
      cyc(0, 0, 1, 1, 2);
      cyc(1, 0, 0, 0, 0);
      lit("wrap_dn", 13, 4'b0100, 0, 1);
`else
      cyc(0, 0, 0, 1, 13);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      lit("lock_dn", 13, 4'b1000, 1, 0);
      cyc(0, 0, 1, 0, 0);
`endif

      cyc(0, 0, 0, 0, 0);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
